// File: rtl/uram_gearbox_pkg.sv
// Shared definitions for the URAM sample gearbox: lane count used by the
// optional output scrambler, phase index type and fill-counter width helper.
package uram_gearbox_pkg;

  localparam int LANES = 3;

  typedef int unsigned phase_idx_t;

  // Fill counter must hold 0..NSAMP_IN+NSAMP_OUT inclusive.
  function automatic int clog2_fill(input int nsamp_in, input int nsamp_out);
    return $clog2(nsamp_in + nsamp_out + 1);
  endfunction

endpackage

// File: rtl/uram_gearbox_lane.sv
// One channel's sample buffer: optional shift-down by NSAMP_OUT, then append
// of an input beat at a caller-supplied fill position. Sample 0 is the oldest.
module uram_gearbox_lane
  import uram_gearbox_pkg::*;
#(
  parameter int NBIT      = 12,
  parameter int NSAMP_IN  = 8,
  parameter int NSAMP_OUT = 6,
  parameter int FW        = clog2_fill(8, 6)
) (
  input  logic                      clk,
  input  logic                      srst,
  input  logic                      i_shift,
  input  logic                      i_load,
  input  logic [FW-1:0]             i_pos,
  input  logic [NSAMP_IN*NBIT-1:0]  i_dat,
  output logic [NSAMP_OUT*NBIT-1:0] o_head
);

  localparam int DEPTH = NSAMP_IN + NSAMP_OUT;

  logic [NBIT-1:0] r_buf      [DEPTH];
  logic [NBIT-1:0] w_buf_next [DEPTH];

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_pos
    logic [NBIT-1:0] w_shifted;
    logic [NBIT-1:0] w_app;
    logic [FW:0]     w_off;
    logic            w_in_win;

    if (gi + NSAMP_OUT < DEPTH) begin : g_sh
      assign w_shifted = i_shift ? r_buf[gi+NSAMP_OUT] : r_buf[gi];
    end else begin : g_tail
      assign w_shifted = i_shift ? '0 : r_buf[gi];
    end

    // Offset of this slot inside the incoming beat; only meaningful when gi >= i_pos.
    assign w_off    = (FW+1)'(gi) - {1'b0, i_pos};
    assign w_in_win = i_load && ({1'b0, i_pos} <= (FW+1)'(gi))
                      && (w_off < (FW+1)'(NSAMP_IN));

    always_comb begin
      w_app = '0;
      for (int k = 0; k < NSAMP_IN; k++) begin
        if (w_off == (FW+1)'(k)) w_app = i_dat[k*NBIT +: NBIT];
      end
    end

    assign w_buf_next[gi] = w_in_win ? w_app : w_shifted;
  end

  for (gi = 0; gi < NSAMP_OUT; gi++) begin : g_head
    assign o_head[gi*NBIT +: NBIT] = r_buf[gi];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int j = 0; j < DEPTH; j++) r_buf[j] <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) r_buf[j] <= w_buf_next[j];
    end
  end

endmodule

// File: rtl/uram_sample_gearbox.sv
// Multi-channel NSAMP_IN -> NSAMP_OUT sample gearbox with sync realignment,
// sticky overflow and output phase index. Define URAM_SCRAMBLE_EN for lane rotation.
module uram_sample_gearbox
  import uram_gearbox_pkg::*;
#(
  parameter int NCHAN     = 1,
  parameter int NBIT      = 12,
  parameter int NSAMP_IN  = 8,
  parameter int NSAMP_OUT = 6,
  parameter int NPHASE    = 4
) (
  input  logic                            memclk_i,
  input  logic                            memclk_rst_i,
  input  logic                            sync_i,
  input  logic [NCHAN*NSAMP_IN*NBIT-1:0]  dat_i,
  input  logic                            valid_i,
  output logic [NCHAN*NSAMP_OUT*NBIT-1:0] dat_o,
  output logic                            valid_o,
  output logic [$clog2(NPHASE)-1:0]       phase_o,
  output logic                            overflow_o
);

  localparam int DEPTH = NSAMP_IN + NSAMP_OUT;
  localparam int FW    = clog2_fill(NSAMP_IN, NSAMP_OUT);
  localparam int PW    = $clog2(NPHASE);
  localparam int CW    = NSAMP_OUT * NBIT;
  localparam phase_idx_t PHASE_LAST = phase_idx_t'(NPHASE - 1);

  logic [FW-1:0]       r_fill;
  logic [PW-1:0]       r_phase;
  logic [PW-1:0]       r_phase_out;
  logic                r_valid;
  logic                r_overflow;
  logic [NCHAN*CW-1:0] r_dat;

  logic [FW-1:0]       w_f1;
  logic [FW-1:0]       w_fill_next;
  logic [NCHAN*CW-1:0] w_dat_next;
  logic                w_emit;
  logic                w_fits;
  logic                w_load;

  assign w_emit = (r_fill >= FW'(NSAMP_OUT)) && !sync_i;

  always_comb begin
    w_f1 = r_fill;
    if (sync_i)      w_f1 = '0;
    else if (w_emit) w_f1 = r_fill - FW'(NSAMP_OUT);
  end

  // One extra bit so f1+NSAMP_IN cannot wrap before the depth compare.
  assign w_fits      = ({1'b0, w_f1} + (FW+1)'(NSAMP_IN)) <= (FW+1)'(DEPTH);
  assign w_load      = valid_i && w_fits;
  assign w_fill_next = w_load ? w_f1 + FW'(NSAMP_IN) : w_f1;

`ifdef URAM_SCRAMBLE_EN
  phase_idx_t w_rot;
  assign w_rot = phase_idx_t'(r_phase) % phase_idx_t'(LANES);
`endif

  genvar gi;
  for (gi = 0; gi < NCHAN; gi++) begin : g_chan
    logic [CW-1:0] w_head;
    logic [CW-1:0] w_out;

    uram_gearbox_lane #(
      .NBIT      (NBIT),
      .NSAMP_IN  (NSAMP_IN),
      .NSAMP_OUT (NSAMP_OUT),
      .FW        (FW)
    ) u_lane (
      .clk     (memclk_i),
      .srst    (memclk_rst_i),
      .i_shift (w_emit),
      .i_load  (w_load),
      .i_pos   (w_f1),
      .i_dat   (dat_i[gi*NSAMP_IN*NBIT +: NSAMP_IN*NBIT]),
      .o_head  (w_head)
    );

`ifdef URAM_SCRAMBLE_EN
    localparam int LW = (NSAMP_OUT / LANES) * NBIT;
    // Lane m of the buffer slice lands in output lane (m + phase) mod 3.
    always_comb begin
      w_out = w_head;
      for (int m = 0; m < LANES; m++) begin
        w_out[((phase_idx_t'(m) + w_rot) % phase_idx_t'(LANES))*LW +: LW] = w_head[m*LW +: LW];
      end
    end
`else
    assign w_out = w_head;
`endif

    assign w_dat_next[gi*CW +: CW] = w_out;
  end

  always_ff @(posedge memclk_i) begin
    if (memclk_rst_i) begin
      r_fill      <= '0;
      r_phase     <= '0;
      r_phase_out <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_dat       <= '0;
    end else begin
      r_fill  <= w_fill_next;
      r_valid <= w_emit;
      if (valid_i && !w_fits) r_overflow <= 1'b1;
      if (sync_i) begin
        r_phase <= '0;
      end else if (w_emit) begin
        r_dat       <= w_dat_next;
        r_phase_out <= r_phase;
        r_phase     <= (phase_idx_t'(r_phase) == PHASE_LAST) ? '0 : r_phase + 1'b1;
      end
    end
  end

  assign dat_o      = r_dat;
  assign valid_o    = r_valid;
  assign phase_o    = r_phase_out;
  assign overflow_o = r_overflow;

endmodule
